// File: rtl/approx_add_pkg.sv
// Shared definitions for the split approximate adder and its error monitor.
//   DEF_WIDTH / DEF_SPLIT : default operand width and approximate low-part width
//   CNT_W / ACC_W         : widths of the statistics counters and |err| accumulator
//   approx_add()          : approximate sum for the default widths, shared with
//                           the adder's testbench
package approx_add_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SPLIT = 16;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned ACC_W     = 48;

  function automatic logic [DEF_WIDTH:0] approx_add(input logic [DEF_WIDTH-1:0] a,
                                                    input logic [DEF_WIDTH-1:0] b);
    logic                           cmsp;
    logic [DEF_WIDTH-DEF_SPLIT:0]   upper;
    cmsp  = a[DEF_SPLIT-1] & b[DEF_SPLIT-1];
    upper = {1'b0, a[DEF_WIDTH-1:DEF_SPLIT]} + {1'b0, b[DEF_WIDTH-1:DEF_SPLIT]}
          + {{(DEF_WIDTH-DEF_SPLIT){1'b0}}, cmsp};
    return {upper, a[DEF_SPLIT-1] ^ b[DEF_SPLIT-1] ^ cmsp,
            a[DEF_SPLIT-2:0] | b[DEF_SPLIT-2:0]};
  endfunction

endpackage

// File: rtl/approx_split_adder.sv
// Combinational split approximate adder.
//   a, b : operands (WIDTH bits)
//   sum  : approximate sum (WIDTH+1 bits)
//   cmsp : speculative carry generated from bit SPLIT-1 of both operands
// Bits [SPLIT-2:0] are OR-approximated; bit SPLIT-1 feeds the speculative carry
// into the exact upper adder.
module approx_split_adder
  import approx_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SPLIT = DEF_SPLIT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum,
  output logic             cmsp
);

  localparam int unsigned UW = WIDTH - SPLIT;

  logic [UW:0] upper;

  always_comb begin
    cmsp  = a[SPLIT-1] & b[SPLIT-1];
    upper = {1'b0, a[WIDTH-1:SPLIT]} + {1'b0, b[WIDTH-1:SPLIT]} + {{UW{1'b0}}, cmsp};
    sum   = {upper, a[SPLIT-1] ^ b[SPLIT-1] ^ cmsp, a[SPLIT-2:0] | b[SPLIT-2:0]};
  end

endmodule

// File: rtl/approx_add_err_monitor.sv
// Error monitor for the split approximate adder.
// Accepts operand pairs (in_valid/in_ready), recomputes approximate and exact
// sums, and emits the signed error exact-approx (out_valid/out_ready) after a
// two-stage pipeline. Running error statistics are kept when the build defines
// APPROX_ERR_STATS_EN; otherwise they read 0 and stat_clear is ignored.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid, in_ready, a, b                      : operand stream
//   out_valid, out_ready, approx_sum, exact_sum,
//   err (signed SPLIT+1), err_nz                  : result stream
//   stat_clear, sample_cnt, err_cnt, max_abs_err,
//   abs_err_sum                                   : statistics
module approx_add_err_monitor
  import approx_add_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SPLIT = DEF_SPLIT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   approx_sum,
  output logic [WIDTH:0]   exact_sum,
  output logic [SPLIT:0]   err,
  output logic             err_nz,
  input  logic             stat_clear,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SPLIT-1:0] max_abs_err,
  output logic [ACC_W-1:0] abs_err_sum
);

  logic             s1_valid, s2_valid;
  logic             s2_ready, s1_load, s2_load;
  logic [WIDTH:0]   approx_c, exact_c;
  logic             cmsp_c;
  logic [WIDTH:0]   s1_approx, s1_exact;
  logic [SPLIT-1:0] s1_and;
  logic             s1_cmsp;
  logic [SPLIT:0]   err_c, err_neg;
  logic [SPLIT-1:0] abs_c, abs_q;

  approx_split_adder #(.WIDTH(WIDTH), .SPLIT(SPLIT)) u_adder (
    .a    (a),
    .b    (b),
    .sum  (approx_c),
    .cmsp (cmsp_c)
  );

  // Ready depends only on stage occupancy and out_ready, never on in_valid.
  assign s2_ready  = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s2_ready;
  assign s1_load   = in_valid && in_ready;
  assign s2_load   = s1_valid && s2_ready;
  assign out_valid = s2_valid;

  always_comb begin
    exact_c = {1'b0, a} + {1'b0, b};
    // exact - approx reduces to the dropped AND-term minus the speculated carry.
    err_c   = {1'b0, s1_and} - {s1_cmsp, {SPLIT{1'b0}}};
    err_neg = '0 - err_c;
    abs_c   = err_c[SPLIT] ? err_neg[SPLIT-1:0] : err_c[SPLIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_approx <= '0;
      s1_exact  <= '0;
      s1_and    <= '0;
      s1_cmsp   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s1_approx <= approx_c;
        s1_exact  <= exact_c;
        s1_and    <= a[SPLIT-1:0] & b[SPLIT-1:0];
        s1_cmsp   <= cmsp_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid   <= 1'b0;
      approx_sum <= '0;
      exact_sum  <= '0;
      err        <= '0;
      abs_q      <= '0;
      err_nz     <= 1'b0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s2_load) begin
        approx_sum <= s1_approx;
        exact_sum  <= s1_exact;
        err        <= err_c;
        abs_q      <= abs_c;
        err_nz     <= |err_c;
      end
    end
  end

`ifdef APPROX_ERR_STATS_EN
  logic             hs_out;
  logic [ACC_W:0]   acc_next;

  assign hs_out   = s2_valid && out_ready;
  assign acc_next = {1'b0, abs_err_sum} + {{(ACC_W+1-SPLIT){1'b0}}, abs_q};

  always_ff @(posedge clk) begin
    if (rst || stat_clear) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      abs_err_sum <= '0;
    end else if (hs_out) begin
      if (sample_cnt != '1)          sample_cnt  <= sample_cnt + 1'b1;
      if (err_nz && err_cnt != '1)   err_cnt     <= err_cnt + 1'b1;
      if (abs_q > max_abs_err)       max_abs_err <= abs_q;
      abs_err_sum <= acc_next[ACC_W] ? '1 : acc_next[ACC_W-1:0];
    end
  end
`else
  logic stats_unused;
  assign stats_unused = stat_clear | (|abs_q);
  assign sample_cnt   = '0;
  assign err_cnt      = '0;
  assign max_abs_err  = '0;
  assign abs_err_sum  = '0;
`endif

endmodule

// File: tb/tb_approx_add_err_monitor.sv
module tb_approx_add_err_monitor;
  import approx_add_pkg::*;

  localparam int W = 32;
  localparam int K = 16;
`ifdef APPROX_ERR_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, in_valid, in_ready, out_valid, out_ready, err_nz, stat_clear;
  logic [W-1:0]  a, b;
  logic [W:0]    approx_sum, exact_sum;
  logic [K:0]    err;
  logic [31:0]   sample_cnt, err_cnt;
  logic [K-1:0]  max_abs_err;
  logic [47:0]   abs_err_sum;

  logic rdy_val = 1'b1, rdy_rand = 1'b0, rand_bit = 1'b1, mon_en = 1'b0;
  assign out_ready = rdy_rand ? rand_bit : rdy_val;

  approx_add_err_monitor #(.WIDTH(W), .SPLIT(K)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .approx_sum(approx_sum),
    .exact_sum(exact_sum), .err(err), .err_nz(err_nz), .stat_clear(stat_clear),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .max_abs_err(max_abs_err),
    .abs_err_sum(abs_err_sum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    rand_bit = ($urandom_range(0, 3) != 0);
  end

  int checks = 0, failures = 0;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model: approximate sum as (a|b) mod 2^K plus the exact upper sum
  // including the carry guessed from bit K-1; error is plain exact - approx.
  typedef struct { longint ap; longint ex; longint er; longint t; } exp_t;
  exp_t q[$];

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input longint t);
    exp_t   e;
    longint xa, ya, c;
    xa   = x;
    ya   = y;
    c    = ((xa >> (K-1)) & 1) & ((ya >> (K-1)) & 1);
    e.ex = xa + ya;
    e.ap = ((xa | ya) % (64'sd1 << K)) + (((xa >> K) + (ya >> K) + c) << K);
    e.er = e.ex - e.ap;
    e.t  = t;
    return e;
  endfunction

  longint m_cnt = 0, m_ecnt = 0, m_max = 0, m_sum = 0;
  longint cyc = 0;
  always @(posedge clk) cyc++;

  // Everything is observed on the falling edge: values seen here are what the
  // next rising edge will act on, and outputs reflect all earlier edges.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      check("in_ready", in_ready, !(q.size() >= 2 && !out_ready));
      check("out_valid", out_valid, q.size() > 0 && (cyc - q[0].t) >= 1);
      if (out_valid && q.size() > 0) begin
        check("approx_sum", approx_sum, q[0].ap);
        check("exact_sum", exact_sum, q[0].ex);
        check("err", $signed(err), q[0].er);
        check("err_nz", err_nz, q[0].er != 0);
      end
      check("sample_cnt", sample_cnt, STATS_EN ? m_cnt : 0);
      check("err_cnt", err_cnt, STATS_EN ? m_ecnt : 0);
      check("max_abs_err", max_abs_err, STATS_EN ? m_max : 0);
      check("abs_err_sum", abs_err_sum, STATS_EN ? m_sum : 0);

      if (rst) begin
        q.delete();
        m_cnt = 0; m_ecnt = 0; m_max = 0; m_sum = 0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          longint ab;
          e  = q.pop_front();
          ab = (e.er < 0) ? -e.er : e.er;
          if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
          if (e.er != 0 && m_ecnt < 64'hFFFF_FFFF) m_ecnt++;
          if (ab > m_max) m_max = ab;
          m_sum = (m_sum + ab > 64'hFFFF_FFFF_FFFF) ? 64'hFFFF_FFFF_FFFF : m_sum + ab;
        end
        if (stat_clear) begin
          m_cnt = 0; m_ecnt = 0; m_max = 0; m_sum = 0;
        end
        if (in_valid && in_ready) q.push_back(model(a, b, cyc + 1));
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb);
    int n = 0;
    a = xa; b = xb; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 200);
    check("send_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_stats(input string tag, input longint c, input longint ec,
                             input longint mx, input longint s);
    @(negedge clk);
    check({tag, "_cnt"}, sample_cnt, STATS_EN ? c : 0);
    check({tag, "_errcnt"}, err_cnt, STATS_EN ? ec : 0);
    check({tag, "_max"}, max_abs_err, STATS_EN ? mx : 0);
    check({tag, "_sum"}, abs_err_sum, STATS_EN ? s : 0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; stat_clear = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors
    send(32'h0000FFFF, 32'h00000001);
    send(32'h00008000, 32'h00008000);
    send(32'hFFFFFFFF, 32'h00000001);
    send(32'h12340000, 32'h00010000);
    drain();
    check_stats("tp3", 4, 3, 32768, 32770);

    // stat_clear coincident with an output handshake
    rdy_val = 1'b0;
    send(32'h00000003, 32'h00000001);
    repeat (2) @(posedge clk);
    #1;
    stat_clear = 1'b1; rdy_val = 1'b1;
    @(posedge clk); #1;
    stat_clear = 1'b0;
    check_stats("clr", 0, 0, 0, 0);

    // Backpressure: four back-to-back inputs, consumer stalled for 5 cycles
    rdy_val = 1'b0;
    fork
      begin
        repeat (5) @(posedge clk);
        #1 rdy_val = 1'b1;
      end
      begin
        send(32'h00000001, 32'h00000001);
        send(32'h0000C000, 32'h00008000);
        send(32'h00000000, 32'h00000000);
        send(32'hFFFF7FFF, 32'h00007FFF);
      end
    join
    drain();
    check_stats("bp", 4, 3, 32768, 32768 + 1 + 32767);

    // Reset with two samples in flight
    rdy_val = 1'b0;
    send(32'h00000005, 32'h00000007);
    send(32'h00008001, 32'h00008001);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rdy_val = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check_stats("rst", 0, 0, 0, 0);

    // Randomised traffic with random consumer stalls
    rdy_rand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] x, y;
      x = $urandom; y = $urandom;
      case ($urandom_range(0, 3))
        1: begin x[K-1] = 1'b1; y[K-1] = 1'b1; end
        2: begin x = x & 32'h0000FFFF; y = y & 32'h0000FFFF; end
        3: begin x = ($urandom_range(0, 1) != 0) ? '1 : '0; y[K-1:0] = '1; end
        default: ;
      endcase
      send(x, y);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    drain();
    rdy_rand = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/approx_add_err_monitor.md
Name: approx_add_err_monitor

Overview:
- Checking companion to the team's split approximate adder: consumes operand pairs over a valid/ready stream.
- Recomputes the approximate sum and the exact sum, and emits the signed error per sample over a second valid/ready stream.
- Keeps running error statistics.
- Sits beside the approximate datapath in characterisation benches and on-chip self-test, measuring the accuracy loss of the OR-based low part.

Parameters:
WIDTH, 32, operand width; sums are WIDTH+1 bits
SPLIT, 16, approximate low-part width; bits [SPLIT-2:0] are OR-approximated, bit SPLIT-1 generates the speculative carry

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  monitor can accept
a  in  WIDTH  operand A
b  in  WIDTH  operand B
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
approx_sum  out  WIDTH+1  approximate adder result
exact_sum  out  WIDTH+1  a+b, exact
err  out  SPLIT+1  signed, exact_sum minus approx_sum
err_nz  out  1  err != 0
stat_clear  in  1  synchronous clear of statistics
sample_cnt  out  32  results handed off
err_cnt  out  32  results handed off with err_nz
max_abs_err  out  SPLIT  largest |err| handed off
abs_err_sum  out  48  sum of |err| handed off

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Approximate sum, for K=SPLIT:
  - low[K-2:0] = a|b.
  - cmsp = a[K-1]&b[K-1].
  - low[K-1] = a[K-1]^b[K-1]^cmsp.
  - upper {carry, sum[WIDTH-1:K]} = a[WIDTH-1:K] + b[WIDTH-1:K] + cmsp, zero-extended by one bit.
- Exact sum: zero-extended a+b, WIDTH+1 bits.
- Error:
  - err = (a&b)[K-1:0] - (cmsp<<K), in two's complement on SPLIT+1 bits.
  - Range is [-2^(K-1), 2^(K-1)-1], so err never overflows.
  - |err| fits SPLIT bits.
- Pipeline, two stages:
  - S1 registers approx_sum and exact_sum, plus the operand AND-term and cmsp.
  - S2 registers err, |err| and err_nz.
  - Latency: 2 cycles from input handshake to out_valid. Throughput is 1 per cycle while out_ready=1.
- Flow control:
  - A stage loads when it is empty or its contents move on in the same cycle.
  - in_ready = !S1_valid || S1 advancing. in_ready is purely registered-state driven plus out_ready; it has no combinational path from in_valid.
  - Order is preserved and nothing is dropped or duplicated.
  - While out_valid=1 and out_ready=0, all outputs hold stable.
- Statistics:
  - Updated only on an output handshake (out_valid&out_ready).
  - sample_cnt+1; err_cnt+1 if err_nz; max_abs_err=max; abs_err_sum+=|err|.
  - All statistics saturate at all-ones and never wrap.
- stat_clear:
  - Zeroes all statistics the next cycle and takes priority over a coincident handshake; that sample is not counted.
  - Does not affect the pipeline.
- Reset values: out_valid=0, in_ready=1 in the cycle after rst deasserts, data outputs 0, all statistics 0.
- Reset mid-operation: in-flight samples are discarded, nothing is counted, and the pipeline restarts empty.
- Simultaneous in_valid with full stalled pipeline: no accept (in_ready=0); the operands must be held by the source.

Optional Feature:
- Macro: APPROX_ERR_STATS_EN.
- Defined: the statistics counters and stat_clear behave as above.
- Undefined:
  - The counters are not instantiated; sample_cnt, err_cnt, max_abs_err and abs_err_sum are tied to 0.
  - stat_clear is ignored.
  - Datapath and handshake are unchanged.

Decomposition:
- Shared package approx_add_pkg:
  - Default WIDTH/SPLIT constants.
  - Statistics widths (32, 48).
  - A function returning the approximate sum for given operands, shared with the adder's testbench.
- Sub-module approx_split_adder: combinational approximate sum parameterised by WIDTH/SPLIT, instantiated in S1.

Test Plan:
- a=0x0000FFFF, b=0x00000001 -> approx 0x00000FFFF, exact 0x000010000, err=+1, err_nz=1, out_valid 2 cycles after accept.
- a=0x00008000, b=0x00008000 -> approx 0x000018000, exact 0x000010000, err=-32768 (0x18000), max_abs_err=0x8000.
- a=0xFFFFFFFF, b=0x00000001 -> approx 0x0FFFFFFFF, exact 0x100000000, err=+1; a=0x12340000, b=0x00010000 -> err=0, err_nz=0.
- Backpressure: 4 back-to-back inputs with out_ready=0 for 5 cycles -> in_ready=0 once two samples are held, outputs stable, all 4 delivered in order after release, sample_cnt=4.
- After the first three scenarios (4 results) -> sample_cnt=4, err_cnt=3, abs_err_sum=32770. Assert stat_clear on the same cycle as a handshake -> all statistics 0 next cycle, that sample not counted.
- Assert rst with 2 samples in flight -> out_valid=0 and statistics 0 next cycle, no stale results emitted afterwards.
